// File: rtl/pwm_pcm_pkg.sv
// Shared types and constants for the PWM -> PCM demodulator.
// Frame constants below describe the default 16-bit build.
package pwm_pcm_pkg;

    typedef enum logic {
        SEEK  = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam int W_DEFAULT = 16;
    localparam int FRAME_LEN = 2 ** W_DEFAULT;
    localparam int PCM_MIN   = -(2 ** (W_DEFAULT - 1));
    localparam int PCM_MAX   = (2 ** (W_DEFAULT - 1)) - 1;

endpackage

// File: rtl/pwm_sync_edge.sv
// Synchroniser, optional majority-of-3 deglitch and rising-edge detect.
// Deglitch filter is built when PWM_TO_PCM_DEGLITCH_EN is defined.
module pwm_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic pwm_s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl;
    logic                   lvl_d;

    // Bring the asynchronous PWM input into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
        end
    end

`ifdef PWM_TO_PCM_DEGLITCH_EN
    logic [1:0] hist;

    // Keep the two previous synchronised samples for the vote.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
        end else begin
            hist <= {hist[0], sync_q[SYNC_STAGES-1]};
        end
    end

    assign lvl = (sync_q[SYNC_STAGES-1] & hist[0]) |
                 (sync_q[SYNC_STAGES-1] & hist[1]) |
                 (hist[0] & hist[1]);
`else
    assign lvl = sync_q[SYNC_STAGES-1];
`endif

    // Delayed level for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_d <= 1'b0;
        end else begin
            lvl_d <= lvl;
        end
    end

    assign pwm_s = lvl;
    assign rise  = lvl & ~lvl_d;

endmodule

// File: rtl/pwm_to_pcm.sv
// PWM -> signed PCM demodulator: counts high cycles over 2**W-cycle frames.
// Option macro: PWM_TO_PCM_DEGLITCH_EN (majority-of-3 input filter).
module pwm_to_pcm
    import pwm_pcm_pkg::*;
#(
    parameter int W           = W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pwm_in,
    output logic [W-1:0] pcm_out,
    output logic         pcm_valid,
    input  logic         pcm_ready,
    output logic         locked,
    output logic         overrun,
    input  logic         clr_flags
);

    state_t       state;
    state_t       state_nxt;
    logic         pwm_s;
    logic         rise;
    logic [W-1:0] frame_cnt;
    logic [W:0]   high_cnt;
    logic [W:0]   high_final;
    logic [W-1:0] sample;
    logic         restart;
    logic         mid_rise;
    logic         frame_end;
    logic         ovr_set;

    pwm_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pwm_in(pwm_in),
        .pwm_s (pwm_s),
        .rise  (rise)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEEK;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave SEEK on the first rising edge, then track forever.
    always_comb begin
        state_nxt = state;
        unique case (state)
            SEEK:    if (rise) state_nxt = TRACK;
            TRACK:   state_nxt = TRACK;
            default: state_nxt = SEEK;
        endcase
    end

    // FSM outputs: frame restart, mid-frame edge and frame completion.
    always_comb begin
        mid_rise  = (state == TRACK) && rise && (frame_cnt != '0);
        restart   = ((state == SEEK) && rise) || mid_rise;
        frame_end = (state == TRACK) && (frame_cnt == '1) && !mid_rise;
    end

    // Final count includes the current cycle; full-high frame saturates.
    assign high_final = high_cnt + {{W{1'b0}}, pwm_s};
    assign sample     = high_final[W] ? {1'b0, {(W-1){1'b1}}}
                                      : {~high_final[W-1], high_final[W-2:0]};
    assign ovr_set    = frame_end && pcm_valid && !pcm_ready;

    // Frame and high-cycle counters; frame_cnt holds the current cycle index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            high_cnt  <= '0;
        end else if (restart) begin
            frame_cnt <= W'(1);
            high_cnt  <= (W+1)'(1);
        end else if (state == TRACK) begin
            frame_cnt <= frame_cnt + W'(1);
            high_cnt  <= frame_end ? '0 : high_final;
        end
    end

    // Lock indication: set by a complete frame, cleared by a mid-frame edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked <= 1'b0;
        end else if (mid_rise) begin
            locked <= 1'b0;
        end else if (frame_end) begin
            locked <= 1'b1;
        end
    end

    // Output register with valid/ready; a full register drops new samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcm_out   <= '0;
            pcm_valid <= 1'b0;
        end else if (frame_end && !ovr_set) begin
            pcm_out   <= sample;
            pcm_valid <= 1'b1;
        end else if (pcm_valid && pcm_ready) begin
            pcm_valid <= 1'b0;
        end
    end

    // Sticky overrun; a new event wins over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else begin
            overrun <= ovr_set | (overrun & ~clr_flags);
        end
    end

endmodule

// File: tb/tb_pwm_to_pcm.sv
// Directed bench for pwm_to_pcm with a small W so frames stay short.
// Encoder model: frame starts high at count -2**(W-1), high for val+2**(W-1) cycles.
module tb_pwm_to_pcm;

    localparam int W    = 6;
    localparam int FLEN = 64;
    localparam int HALF = 32;

    logic         clk;
    logic         rst_n;
    logic         pwm_in;
    logic [W-1:0] pcm_out;
    logic         pcm_valid;
    logic         pcm_ready;
    logic         locked;
    logic         overrun;
    logic         clr_flags;

    int n_chk;
    int n_err;

    // Encoder queue entries: [5:0] value, [6] force high, [7] glitch at cycle 20.
    logic [7:0]   enc_q[$];
    logic [7:0]   cur;
    logic         enc_run;
    int           epos;
    int           nxt;
    int           hc;
    logic [W-1:0] cap[$];

    pwm_to_pcm #(
        .W(W),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pwm_in   (pwm_in),
        .pcm_out  (pcm_out),
        .pcm_valid(pcm_valid),
        .pcm_ready(pcm_ready),
        .locked   (locked),
        .overrun  (overrun),
        .clr_flags(clr_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cap_at(input int i);
        if (i < cap.size()) return {26'b0, cap[i]};
        return 32'hDEAD;
    endfunction

    // Encoder model.
    initial begin
        pwm_in = 1'b0;
        cur    = 8'h00;
        epos   = 0;
        nxt    = 0;
        hc     = 0;
        wait (enc_run);
        forever begin
            @(posedge clk);
            #1;
            epos = nxt;
            nxt  = (nxt + 1) % FLEN;
            if (epos == 0 && enc_q.size() > 0) cur = enc_q.pop_front();
            hc = int'($signed(cur[5:0])) + HALF;
            pwm_in = cur[6] | (cur[7] & (epos == 20)) | (epos < hc);
        end
    end

    // Record every accepted sample.
    always @(negedge clk) begin
        if (rst_n && pcm_valid && pcm_ready) cap.push_back(pcm_out);
    end

    task automatic wait_pos(input int p);
        int n;
        n = 0;
        @(posedge clk);
        #2;
        while (epos != p && n < 4 * FLEN) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (epos != p) chk("wait_pos", epos, p);
    endtask

    initial begin
        n_chk     = 0;
        n_err     = 0;
        enc_run   = 1'b0;
        rst_n     = 1'b0;
        pcm_ready = 1'b1;
        clr_flags = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_pcm_out", pcm_out, 0);
        chk("rst_valid", pcm_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        enc_run = 1'b1;

        // 1: value 0, free-running sink.
        wait_pos(10);
        cap.delete();
        wait_pos(10);
        wait_pos(10);
        chk("t1_count", cap.size(), 2);
        chk("t1_s0", cap_at(0), 32'h00);
        chk("t1_s1", cap_at(1), 32'h00);
        chk("t1_locked", locked, 1);

        // 2: sequence of values comes out in order.
        cap.delete();
        enc_q.push_back(8'h1F);
        enc_q.push_back(8'h21);
        enc_q.push_back(8'h12);
        enc_q.push_back(8'h30);
        repeat (5) wait_pos(10);
        chk("t2_count", cap.size(), 5);
        chk("t2_s0", cap_at(0), 32'h00);
        chk("t2_s1", cap_at(1), 32'h1F);
        chk("t2_s2", cap_at(2), 32'h21);
        chk("t2_s3", cap_at(3), 32'h12);
        chk("t2_s4", cap_at(4), 32'h30);
        chk("t2_overrun", overrun, 0);

        // 3: constant low, forced high (saturated), then high-start frame.
        cap.delete();
        enc_q.push_back(8'h20);
        enc_q.push_back(8'h20);
        enc_q.push_back(8'h40);
        enc_q.push_back(8'h00);
        repeat (5) wait_pos(10);
        chk("t3_count", cap.size(), 5);
        chk("t3_s0", cap_at(0), 32'h30);
        chk("t3_s1", cap_at(1), 32'h20);
        chk("t3_s2", cap_at(2), 32'h20);
        chk("t3_sat", cap_at(3), 32'h1F);
        chk("t3_s4", cap_at(4), 32'h00);
        chk("t3_locked", locked, 1);

        // 4: stalled sink -> hold first, drop second, overrun.
        enc_q.push_back(8'h05);
        enc_q.push_back(8'h0C);
        wait_pos(10);
        pcm_ready = 1'b0;
        cap.delete();
        wait_pos(10);
        chk("t4_hold_valid", pcm_valid, 1);
        chk("t4_hold_val", pcm_out, 32'h05);
        chk("t4_no_ovr", overrun, 0);
        wait_pos(10);
        chk("t4_kept_val", pcm_out, 32'h05);
        chk("t4_ovr", overrun, 1);
        clr_flags = 1'b1;
        @(posedge clk);
        #2;
        clr_flags = 1'b0;
        chk("t4_clr", overrun, 0);
        pcm_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("t4_drain_cnt", cap.size(), 1);
        chk("t4_drain_val", cap_at(0), 32'h05);

        // 5: extra mid-frame rise -> frame discarded, relock on next.
        wait_pos(10);
        cap.delete();
        enc_q.push_back(8'hB0);
        enc_q.push_back(8'h0A);
        wait_pos(10);
        wait_pos(10);
        chk("t5_unlocked", locked, 0);
        chk("t5_cnt_a", cap.size(), 1);
        chk("t5_prev", cap_at(0), 32'h0C);
        wait_pos(10);
        chk("t5_cnt_b", cap.size(), 2);
        chk("t5_relock_val", cap_at(1), 32'h0A);
        chk("t5_relock", locked, 1);

        // 6: reset mid-frame clears outputs; partial frame gives nothing.
        wait_pos(30);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_out", pcm_out, 0);
        chk("t6_rst_locked", locked, 0);
        chk("t6_rst_valid", pcm_valid, 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        cap.delete();
        wait_pos(10);
        chk("t6_nosample", cap.size(), 0);
        chk("t6_novalid", pcm_valid, 0);
        wait_pos(10);
        chk("t6_cnt", cap.size(), 1);
        chk("t6_val", cap_at(0), 32'h0A);
        chk("t6_locked", locked, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
